rle_encoder: RTL and testbench

- Run-length encoder sitting directly downstream of the accumulator state machine; consumes its 16-bit `signal_out` sample stream.
- Collapses repeated consecutive samples into (value, run_count) pairs.
- Pairs are buffered in a small FIFO and presented on a valid/ready output interface, so a slower sink can drain them.
- The upstream stage has no backpressure. Inputs are never stalled; an overrun is flagged, not absorbed.

---
 rtl/rle_encoder_if.sv | 27 ++
 rtl/rle_encoder.sv | 134 +++++++++++++
 tb/tb_rle_encoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rle_encoder_if.sv
// Stream-side bundle for the run-length encoder: sample input, pair output, status.
interface rle_encoder_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              flush;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic              busy;

  // Producer/sink side: drives samples and ready, observes pairs and status.
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  out_data, out_count, out_valid, overflow, busy
  );

  // Encoder side.
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output out_data, out_count, out_valid, overflow, busy
  );
endinterface

// File: rtl/rle_encoder.sv
// Run-length encoder: collapses repeated consecutive samples into (value, count)
// pairs and buffers them in a small FIFO behind a valid/ready output.
// The upstream stream is never stalled; a pair that finds the FIFO full is
// dropped and recorded in a sticky overflow flag.
module rle_encoder #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  rle_encoder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);

  // Run tracking
  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] cur_val_q, cur_val_d;
  logic [CNT_W-1:0]  cur_cnt_q, cur_cnt_d;
  logic              push;

  // FIFO storage; pointers carry one extra bit to tell full from empty
  logic [DATA_W-1:0] mem_val_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_cnt_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              overflow_q;

  logic [AW:0]       occupancy;
  logic              empty, full, pop, wr_en;
  logic [AW-1:0]     rd_idx, wr_idx;

  // Next run state; a push always carries the run being closed (cur_val_q, cur_cnt_q)
  always_comb begin
    state_d   = state_q;
    cur_val_d = cur_val_q;
    cur_cnt_d = cur_cnt_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = RUN;
          cur_val_d = bus.in_data;
          cur_cnt_d = CNT_ONE;
        end
      end
      RUN: begin
        if (bus.flush) begin
          // flush closes the run even if the same-cycle sample would extend it
          push = 1'b1;
          if (bus.in_valid) begin
            cur_val_d = bus.in_data;
            cur_cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.in_valid) begin
          if (bus.in_data == cur_val_q) begin
            if (cur_cnt_q != CNT_MAX) begin
              cur_cnt_d = cur_cnt_q + CNT_ONE;
            end else begin
              // saturated: emit a full-length pair and keep counting the same value
              push      = 1'b1;
              cur_cnt_d = CNT_ONE;
            end
          end else begin
            push      = 1'b1;
            cur_val_d = bus.in_data;
            cur_cnt_d = CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Run state registers; reset drops any open run
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_val_q <= '0;
      cur_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_val_q <= cur_val_d;
      cur_cnt_q <= cur_cnt_d;
    end
  end

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == DEPTH_C);
  assign pop       = ~empty & bus.out_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en     = push & (~full | pop);
  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign wr_idx    = wr_ptr_q[AW-1:0];

  // FIFO pointers and sticky overflow; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push & full & ~pop) overflow_q <= 1'b1;
    end
  end

  // FIFO payload storage; contents are only visible through non-empty slots
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_val_q[wr_idx] <= cur_val_q;
      mem_cnt_q[wr_idx] <= cur_cnt_q;
    end
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : mem_val_q[rd_idx];
  assign bus.out_count = empty ? '0 : mem_cnt_q[rd_idx];
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state_q == RUN) | ~empty;

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: reset, basic runs, saturation, flush,
// backpressure/overflow and full-FIFO push+pop.
module tb_rle_encoder;

  localparam int DATA_W     = 16;
  localparam int CNT_W      = 8;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  rle_encoder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  rle_encoder #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [15:0] val, input logic [7:0] cnt);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_data"},  {16'd0, bus.out_data},  {16'd0, val});
    chk({tag, "_count"}, {24'd0, bus.out_count}, {24'd0, cnt});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_data"},  {16'd0, bus.out_data},  32'd0);
    chk({tag, "_count"}, {24'd0, bus.out_count}, 32'd0);
  endtask

  task automatic sample(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_empty("reset0");
    chk("reset0_ovf",  {31'd0, bus.overflow}, 32'd0);
    chk("reset0_busy", {31'd0, bus.busy},     32'd0);
    rst = 1'b0;

    // Basic runs 5,5,5,7,7,9
    sample(16'd5);
    chk("basic_busy1", {31'd0, bus.busy}, 32'd1);
    chk("basic_nv1",   {31'd0, bus.out_valid}, 32'd0);
    sample(16'd5);
    sample(16'd5);
    chk("basic_nv3",   {31'd0, bus.out_valid}, 32'd0);
    sample(16'd7);
    chk_head("basic_p5", 16'd5, 8'd3);
    sample(16'd7);
    chk_empty("basic_pop5");
    sample(16'd9);
    chk_head("basic_p7", 16'd7, 8'd2);
    bus.in_valid = 1'b0;
    tick();
    chk_empty("basic_pop7");
    chk("basic_busy9", {31'd0, bus.busy}, 32'd1);

    // Reset mid-run with a buffered pair
    bus.out_ready = 1'b0;
    sample(16'd4);
    chk_head("mid_buf9", 16'd9, 8'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_empty("mid_rst");
    chk("mid_rst_ovf",  {31'd0, bus.overflow}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy},     32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    sample(16'd8);
    chk("fresh_busy", {31'd0, bus.busy}, 32'd1);
    chk("fresh_nv",   {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    chk_head("fresh_p8", 16'd8, 8'd1);
    bus.flush = 1'b0;
    tick();
    chk_empty("fresh_pop");
    chk("fresh_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Flush while idle does nothing
    bus.flush = 1'b1;
    tick();
    chk("idle_flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_flush_nv",   {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0;

    // Saturation: 300 samples of 0x00AA
    for (int i = 1; i <= 300; i++) begin
      sample(16'h00AA);
      if (i == 255) chk("sat_nv255", {31'd0, bus.out_valid}, 32'd0);
      if (i == 256) chk_head("sat_p255", 16'h00AA, 8'd255);
      if (i == 257) chk("sat_pop", {31'd0, bus.out_valid}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    chk_head("sat_p45", 16'h00AA, 8'd45);
    bus.flush = 1'b0;
    tick();
    chk_empty("sat_done");
    chk("sat_busy", {31'd0, bus.busy}, 32'd0);

    // Flush with in_valid of the same value
    repeat (4) sample(16'd3);
    bus.flush = 1'b1;
    sample(16'd3);
    chk_head("fv_p34", 16'd3, 8'd4);
    chk("fv_busy", {31'd0, bus.busy}, 32'd1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("fv_pop", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b1;
    tick();
    chk_head("fv_p31", 16'd3, 8'd1);
    bus.flush = 1'b0;
    tick();
    chk_empty("fv_done");

    // Backpressure and overflow
    bus.out_ready = 1'b0;
    sample(16'd10);
    sample(16'd11);
    sample(16'd12);
    sample(16'd13);
    sample(16'd14);
    chk_head("bp_full", 16'd10, 8'd1);
    chk("bp_ovf0", {31'd0, bus.overflow}, 32'd0);
    sample(16'd15);
    chk("bp_ovf1", {31'd0, bus.overflow}, 32'd1);
    chk_head("bp_stable", 16'd10, 8'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk_head("bp_d11", 16'd11, 8'd1);
    tick();
    chk_head("bp_d12", 16'd12, 8'd1);
    tick();
    chk_head("bp_d13", 16'd13, 8'd1);
    tick();
    chk_empty("bp_drained");
    chk("bp_ovf_still", {31'd0, bus.overflow}, 32'd1);
    chk("bp_busy15",    {31'd0, bus.busy},     32'd1);

    // Full FIFO with simultaneous push and pop
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    sample(16'd20);
    sample(16'd21);
    sample(16'd22);
    sample(16'd23);
    sample(16'd24);
    chk_head("pp_full", 16'd20, 8'd1);
    bus.out_ready = 1'b1;
    sample(16'd25);
    chk("pp_ovf", {31'd0, bus.overflow}, 32'd0);
    chk_head("pp_h21", 16'd21, 8'd1);
    bus.in_valid = 1'b0;
    tick();
    chk_head("pp_h22", 16'd22, 8'd1);
    tick();
    chk_head("pp_h23", 16'd23, 8'd1);
    tick();
    chk_head("pp_h24", 16'd24, 8'd1);
    tick();
    chk_empty("pp_drained");
    chk("pp_ovf_end", {31'd0, bus.overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
